// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, FSM encodings and baud divisor helper for the UART command link.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_state_t;
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronised UART receiver with centre sampling, parity and framing checks.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV       = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 read_rdy,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_perr,
  output logic                 read_ferr
);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic rs, rs_d, tick;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic pbit, pbit_n, facc, facc_n, rdy_n, perr_n, ferr_n;
  assign rs = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync      <= 2'b11;
      rs_d      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sh        <= '0;
      pbit      <= 1'b0;
      facc      <= 1'b0;
      read_rdy  <= 1'b0;
      read_data <= '0;
      read_perr <= 1'b0;
      read_ferr <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rs_d      <= rs;
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      sh        <= sh_n;
      pbit      <= pbit_n;
      facc      <= facc_n;
      read_rdy  <= rdy_n;
      read_data <= data_n;
      read_perr <= perr_n;
      read_ferr <= ferr_n;
    end
  // START samples at half a bit; every later sample is a full bit after the previous one
  always_comb begin
    tick    = cnt == (state == RX_START ? HALF : FULL);
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bidx_n  = bidx;
    sh_n    = sh;
    pbit_n  = pbit;
    facc_n  = facc;
    rdy_n   = 1'b0;
    data_n  = read_data;
    perr_n  = read_perr;
    ferr_n  = read_ferr;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rs_d && !rs) state_n = RX_START;
      end
      RX_START: if (tick) begin
        cnt_n   = '0;
        bidx_n  = '0;
        facc_n  = 1'b0;
        state_n = rs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        cnt_n  = '0;
        sh_n   = {rs, sh[DATA_BITS-1:1]};
        bidx_n = bidx + BW'(1);
        if (bidx == DATA_LAST) begin
          bidx_n  = '0;
          state_n = (PARITY == PAR_NONE) ? RX_STOP : RX_PAR;
        end
      end
      RX_PAR: if (tick) begin
        cnt_n   = '0;
        pbit_n  = rs;
        state_n = RX_STOP;
      end
      RX_STOP: if (tick) begin
        cnt_n  = '0;
        bidx_n = bidx + BW'(1);
        facc_n = facc | ~rs;
        if (bidx == STOP_LAST) begin
          rdy_n   = 1'b1;
          data_n  = sh;
          perr_n  = (PARITY != PAR_NONE) && (pbit ^ (^sh) ^ (PARITY == PAR_ODD));
          ferr_n  = facc | ~rs;
          state_n = rs ? RX_IDLE : RX_BRK;
        end
      end
      RX_BRK: begin
        cnt_n = '0;
        if (rs) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: serialises commands into LSB-word-first UART frames and receives UART words.
module uart_cmd_link
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int CMD_WIDTH = 16,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 read_rdy,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_perr,
  output logic                 read_ferr
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int NW  = CMD_WIDTH / DATA_BITS;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int WW  = $clog2(NW + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NW - 1);
  if (CMD_WIDTH % DATA_BITS != 0 || DIV < 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
      (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD)) begin : g_bad_cfg
    $error("uart_cmd_link: unsupported parameter combination");
  end
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [WW-1:0] widx, widx_n;
  logic [CMD_WIDTH-1:0] sbuf, sbuf_n;
  logic par, par_n, tx_n, last;
  assign cmd_rdy = state == TX_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= TX_IDLE;
      cnt   <= '0;
      bidx  <= '0;
      widx  <= '0;
      sbuf  <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      widx  <= widx_n;
      sbuf  <= sbuf_n;
      par   <= par_n;
      tx    <= tx_n;
    end
  // sbuf shifts one bit per data bit, so the next word lands in the low bits by itself
  always_comb begin
    last    = cnt == CNT_LAST;
    state_n = state;
    cnt_n   = (state == TX_IDLE || last) ? '0 : cnt + CW'(1);
    bidx_n  = bidx;
    widx_n  = widx;
    sbuf_n  = sbuf;
    par_n   = par;
    case (state)
      TX_IDLE: if (cmd_vld) begin
        state_n = TX_START;
        sbuf_n  = cmd_in;
        widx_n  = '0;
      end
      TX_START: if (last) begin
        state_n = TX_DATA;
        bidx_n  = '0;
        par_n   = (^sbuf[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD);
      end
      TX_DATA: if (last) begin
        sbuf_n = sbuf >> 1;
        bidx_n = bidx + BW'(1);
        if (bidx == DATA_LAST) begin
          bidx_n  = '0;
          state_n = (PARITY == PAR_NONE) ? TX_STOP : TX_PAR;
        end
      end
      TX_PAR: if (last) state_n = TX_STOP;
      TX_STOP: if (last) begin
        bidx_n = bidx + BW'(1);
        if (bidx == STOP_LAST) begin
          bidx_n  = '0;
          widx_n  = widx + WW'(1);
          state_n = (widx == WORD_LAST) ? TX_IDLE : TX_START;
        end
      end
      default: state_n = TX_IDLE;
    endcase
    tx_n = (state_n == TX_START) ? 1'b0 :
           (state_n == TX_DATA)  ? sbuf_n[0] :
           (state_n == TX_PAR)   ? par_n : 1'b1;
  end
  uart_rx_core #(
    .DIV      (DIV),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .read_rdy (read_rdy),
    .read_data(read_data),
    .read_perr(read_perr),
    .read_ferr(read_ferr)
  );
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link: directed stimulus with scoreboarded TX frame decoding and RX word checking.
module tb_uart_cmd_link;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] cmd_in = '0;
  logic cmd_vld = 1'b0;
  logic cmd_rdy, tx, read_rdy, read_perr, read_ferr;
  logic [7:0] read_data;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic tx_mon_en = 1'b1;
  logic rx_line;
  int vectors = 0;
  int errors = 0;
  int n;
  logic [8:0] txq[$];
  logic [9:0] rxq[$];
  logic [10:0] fr;
  logic [8:0] tx_exp;
  logic [9:0] rx_exp;
  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_cmd_link #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .DATA_BITS(8),
    .CMD_WIDTH(16),
    .PARITY   (1),
    .STOP_BITS(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_in   (cmd_in),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .tx       (tx),
    .rx       (rx_line),
    .read_rdy (read_rdy),
    .read_data(read_data),
    .read_perr(read_perr),
    .read_ferr(read_ferr)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // expected TX frame entry: {parity, data}; expected RX entry: {ferr, perr, data}
  task automatic push_tx(input logic [7:0] d, input logic p);
    txq.push_back({p, d});
  endtask
  task automatic push_rx(input logic [7:0] d, input logic pe, input logic fe);
    rxq.push_back({fe, pe, d});
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = p;
    repeat (DIV) @(negedge clk);
    rx_drv = s;
    repeat (DIV) @(negedge clk);
  endtask
  initial begin
    forever begin
      @(negedge tx);
      if (tx_mon_en) begin
        repeat (DIV / 2) @(negedge clk);
        fr[0] = tx;
        for (int i = 1; i <= 10; i++) begin
          repeat (DIV) @(negedge clk);
          fr[i] = tx;
        end
        if (txq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL tx unexpected frame: got %h expected none", fr);
        end else begin
          tx_exp = txq.pop_front();
          chk("tx frame", 32'(fr), 32'({1'b1, tx_exp[8], tx_exp[7:0], 1'b0}));
        end
      end
    end
  end
  always @(negedge clk)
    if (read_rdy) begin
      if (rxq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rx unexpected word: got %h perr %b ferr %b expected none", read_data, read_perr, read_ferr);
      end else begin
        rx_exp = rxq.pop_front();
        chk("rx word", 32'({read_ferr, read_perr, read_data}), 32'(rx_exp));
      end
    end
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("reset read_rdy", 32'(read_rdy), 32'd0);
    chk("reset read_data", 32'(read_data), 32'd0);
    chk("reset perr", 32'(read_perr), 32'd0);
    chk("reset ferr", 32'(read_ferr), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // T1: single command, late cmd_in change and mid-frame cmd_vld both ignored
    push_tx(8'h5A, 1'b0);
    push_tx(8'hA5, 1'b0);
    cmd_in = 16'hA55A;
    cmd_vld = 1'b1;
    @(negedge clk);
    chk("t1 start bit", 32'({cmd_rdy, tx}), 32'd0);
    cmd_in = 16'hFFFF;
    n = 0;
    while (!cmd_rdy && n < 400) begin
      n++;
      if (n == 50) cmd_vld = 1'b0;
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    chk("t1 busy clocks", 32'(n), 32'd220);
    repeat (20) @(negedge clk);
    // T2: clean RX frame
    push_rx(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    // T3: parity error, then framing error held low as a break
    push_rx(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    push_rx(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    push_rx(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    // T4: short low glitch must not produce a word
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    push_rx(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    // T5: back-to-back commands looped into RX
    loop = 1'b1;
    push_tx(8'h5A, 1'b0);
    push_tx(8'hA5, 1'b0);
    push_tx(8'h81, 1'b0);
    push_tx(8'h6E, 1'b1);
    push_rx(8'h5A, 1'b0, 1'b0);
    push_rx(8'hA5, 1'b0, 1'b0);
    push_rx(8'h81, 1'b0, 1'b0);
    push_rx(8'h6E, 1'b0, 1'b0);
    cmd_in = 16'hA55A;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_in = 16'h6E81;
    n = 0;
    while (!cmd_rdy && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("t5 busy clocks", 32'(n), 32'd220);
    chk("t5 gap line", 32'(tx), 32'd1);
    @(negedge clk);
    cmd_vld = 1'b0;
    chk("t5 second start", 32'({cmd_rdy, tx}), 32'd0);
    repeat (300) @(negedge clk);
    // T6: asynchronous reset during a data bit
    loop = 1'b0;
    tx_mon_en = 1'b0;
    cmd_in = 16'h0000;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (44) @(negedge clk);
    chk("t6 mid-frame line", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6 reset tx", 32'(tx), 32'd1);
    chk("t6 reset cmd_rdy", 32'(cmd_rdy), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_mon_en = 1'b1;
    loop = 1'b1;
    push_tx(8'h37, 1'b1);
    push_tx(8'h0F, 1'b0);
    push_rx(8'h37, 1'b0, 1'b0);
    push_rx(8'h0F, 1'b0, 1'b0);
    cmd_in = 16'h0F37;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (260) @(negedge clk);
    chk("tx queue drained", 32'(txq.size()), 32'd0);
    chk("rx queue drained", 32'(rxq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
